// File: rtl/sayeh_pkg.sv
// ---------------------------------------------------------------------------
// sayeh_pkg
// Shared constants and types for the SAYEH datapath. The register file and
// the arithmetic unit both size their operands from these values.
//   WIDTH     : data word width
//   NREGS     : physical register count (power of two)
//   WPW       : window pointer width, log2(NREGS)
//   win_idx_t : window-relative register index (four visible registers)
// ---------------------------------------------------------------------------
package sayeh_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 64;
    localparam int WPW   = 6;

    typedef logic [1:0] win_idx_t;

endpackage : sayeh_pkg

// File: rtl/window_register_file_flag_register.sv
// ---------------------------------------------------------------------------
// flag_register
// Carry (C) and zero (Z) status flops. Each flag resolves on its own:
// clear beats set, set beats a load from the ALU, otherwise hold.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cout_in, zout_in    : ALU carry / zero outputs
//   sr_load             : load both flags from the ALU
//   c_set, c_reset      : explicit carry controls
//   z_set, z_reset      : explicit zero controls
//   c_flag, z_flag      : registered flags (c_flag feeds ALU carry-in)
// ---------------------------------------------------------------------------
module flag_register (
    input  logic clk,
    input  logic rst_n,
    input  logic cout_in,
    input  logic zout_in,
    input  logic sr_load,
    input  logic c_set,
    input  logic c_reset,
    input  logic z_set,
    input  logic z_reset,
    output logic c_flag,
    output logic z_flag
);

    logic c_q, c_d;
    logic z_q, z_d;

    function automatic logic resolve_flag(input logic cur, input logic set,
                                          input logic clr, input logic load,
                                          input logic load_val);
        if (clr)  return 1'b0;
        if (set)  return 1'b1;
        if (load) return load_val;
        return cur;
    endfunction

    always_comb begin
        c_d = resolve_flag(c_q, c_set, c_reset, sr_load, cout_in);
        z_d = resolve_flag(z_q, z_set, z_reset, sr_load, zout_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign c_flag = c_q;
    assign z_flag = z_q;

endmodule : flag_register

// File: rtl/window_register_file.sv
// ---------------------------------------------------------------------------
// window_register_file
// Windowed register file for the SAYEH datapath: NREGS physical words, of
// which four are visible through the window pointer WP. Drives the ALU A/B
// operands combinationally and captures the ALU result on writeback, with
// independent low/high byte enables. Also hosts the C/Z status flags.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   wp_in, wp_add, wp_reset: window pointer offset / add / clear
//   laddr, raddr           : window-relative left(dest) / right(source) index
//   din                    : writeback data (ALU result)
//   rfl_write, rfh_write   : write low byte / high byte of left register
//   left_out, right_out    : left / right register contents
//   wp_out                 : current window pointer
//   cout_in, zout_in       : ALU flags
//   sr_load, c_set, c_reset, z_set, z_reset : flag controls
//   c_flag, z_flag         : registered flags
// ---------------------------------------------------------------------------
module window_register_file #(
    parameter int WIDTH = sayeh_pkg::WIDTH,
    parameter int NREGS = sayeh_pkg::NREGS,
    parameter int WPW   = sayeh_pkg::WPW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WPW-1:0]      wp_in,
    input  logic                wp_add,
    input  logic                wp_reset,
    input  sayeh_pkg::win_idx_t laddr,
    input  sayeh_pkg::win_idx_t raddr,
    input  logic [WIDTH-1:0]    din,
    input  logic                rfl_write,
    input  logic                rfh_write,
    output logic [WIDTH-1:0]    left_out,
    output logic [WIDTH-1:0]    right_out,
    output logic [WPW-1:0]      wp_out,
    input  logic                cout_in,
    input  logic                zout_in,
    input  logic                sr_load,
    input  logic                c_set,
    input  logic                c_reset,
    input  logic                z_set,
    input  logic                z_reset,
    output logic                c_flag,
    output logic                z_flag
);

    import sayeh_pkg::*;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WPW-1:0]   wp_q, wp_d;
    logic [WPW-1:0]   lphys, rphys;
    logic [WIDTH-1:0] wr_word_d;
    logic             wr_en;

    // Window-relative to physical: the WPW-bit add wraps mod NREGS for free.
    assign lphys = wp_q + WPW'(laddr);
    assign rphys = wp_q + WPW'(raddr);

    // Reads have no write bypass, so a read-modify-write sees old operands.
    assign left_out  = regs_q[lphys];
    assign right_out = regs_q[rphys];
    assign wp_out    = wp_q;

    // Merge the enabled byte lanes of din into the current left word.
    always_comb begin
        wr_en     = rfl_write | rfh_write;
        wr_word_d = regs_q[lphys];
        if (rfl_write) wr_word_d[7:0]       = din[7:0];
        if (rfh_write) wr_word_d[WIDTH-1:8] = din[WIDTH-1:8];
    end

    always_comb begin
        wp_d = wp_q;
        if (wp_reset)    wp_d = '0;
        else if (wp_add) wp_d = wp_q + wp_in;
    end

    // The write address comes from wp_q, so a write concurrent with a WP
    // change lands in the pre-update window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[lphys] <= wr_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wp_q <= '0;
        else        wp_q <= wp_d;
    end

    flag_register u_flags (
        .clk     (clk),
        .rst_n   (rst_n),
        .cout_in (cout_in),
        .zout_in (zout_in),
        .sr_load (sr_load),
        .c_set   (c_set),
        .c_reset (c_reset),
        .z_set   (z_set),
        .z_reset (z_reset),
        .c_flag  (c_flag),
        .z_flag  (z_flag)
    );

endmodule : window_register_file

// File: tb/tb_window_register_file.sv
// ---------------------------------------------------------------------------
// tb_window_register_file
// Directed and random stimulus against a behavioural model of the windowed
// register file; expected outputs are queued by the driver and checked by an
// independent monitor just before each rising edge.
// ---------------------------------------------------------------------------
module tb_window_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  wp_in;
    logic        wp_add, wp_reset;
    logic [1:0]  laddr, raddr;
    logic [15:0] din;
    logic        rfl_write, rfh_write;
    logic [15:0] left_out, right_out;
    logic [5:0]  wp_out;
    logic        cout_in, zout_in, sr_load;
    logic        c_set, c_reset, z_set, z_reset;
    logic        c_flag, z_flag;

    always #5 clk = ~clk;

    window_register_file dut (
        .clk(clk), .rst_n(rst_n), .wp_in(wp_in), .wp_add(wp_add),
        .wp_reset(wp_reset), .laddr(laddr), .raddr(raddr), .din(din),
        .rfl_write(rfl_write), .rfh_write(rfh_write),
        .left_out(left_out), .right_out(right_out), .wp_out(wp_out),
        .cout_in(cout_in), .zout_in(zout_in), .sr_load(sr_load),
        .c_set(c_set), .c_reset(c_reset), .z_set(z_set), .z_reset(z_reset),
        .c_flag(c_flag), .z_flag(z_flag)
    );

    // Reference model state
    logic [15:0] m_mem [64];
    int          m_wp;
    logic        m_c, m_z;

    typedef struct {
        int          id;
        logic [15:0] left;
        logic [15:0] right;
        logic [5:0]  wp;
        logic        c;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;
    bit   chk_en = 0;

    function automatic logic [15:0] m_read(input logic [1:0] idx);
        return m_mem[(m_wp + int'(idx)) % 64];
    endfunction

    // Next state from the behavioural rules, using the inputs seen at the edge.
    task automatic model_update();
        int phys;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
            m_wp = 0;
            m_c  = 1'b0;
            m_z  = 1'b0;
        end else begin
            phys = (m_wp + int'(laddr)) % 64;
            if (rfl_write) m_mem[phys][7:0]  = din[7:0];
            if (rfh_write) m_mem[phys][15:8] = din[15:8];
            if (wp_reset)    m_wp = 0;
            else if (wp_add) m_wp = (m_wp + int'(wp_in)) % 64;
            if (c_reset)      m_c = 1'b0;
            else if (c_set)   m_c = 1'b1;
            else if (sr_load) m_c = cout_in;
            if (z_reset)      m_z = 1'b0;
            else if (z_set)   m_z = 1'b1;
            else if (sr_load) m_z = zout_in;
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; wp_in = '0; wp_add = 0; wp_reset = 0;
        laddr = 0; raddr = 0; din = '0; rfl_write = 0; rfh_write = 0;
        cout_in = 0; zout_in = 0; sr_load = 0;
        c_set = 0; c_reset = 0; z_set = 0; z_reset = 0;
    endtask

    // Queue what the outputs must show for the inputs now driven, then
    // advance one edge.
    task automatic cycle();
        exp_t e;
        if (chk_en) begin
            e.id    = step_id;
            e.left  = m_read(laddr);
            e.right = m_read(raddr);
            e.wp    = 6'(m_wp);
            e.c     = m_c;
            e.z     = m_z;
            exp_q.push_back(e);
        end
        step_id++;
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic write(input logic [1:0] idx, input logic [15:0] d,
                         input logic lo, input logic hi);
        idle(); laddr = idx; din = d; rfl_write = lo; rfh_write = hi; cycle();
    endtask

    task automatic look(input logic [1:0] l, input logic [1:0] r);
        idle(); laddr = l; raddr = r; cycle();
    endtask

    // Monitor: compare just before the rising edge, away from it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (left_out !== mon_e.left || right_out !== mon_e.right ||
                wp_out !== mon_e.wp || c_flag !== mon_e.c || z_flag !== mon_e.z) begin
                n_bad++;
                $display("FAIL step%0d: got left=%h right=%h wp=%0d c=%b z=%b, expected left=%h right=%h wp=%0d c=%b z=%b",
                         mon_e.id, left_out, right_out, wp_out, c_flag, z_flag,
                         mon_e.left, mon_e.right, mon_e.wp, mon_e.c, mon_e.z);
            end
        end
    end

    initial begin
        int wait_cnt;
        idle();
        for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
        m_wp = 0; m_c = 0; m_z = 0;
        #2;

        // Reset with a conflicting full write and flag commands pending.
        rst_n = 0; rfl_write = 1; rfh_write = 1; din = 16'hFFFF;
        c_set = 1; z_set = 1; wp_add = 1; wp_in = 6'd5;
        cycle();
        chk_en = 1;
        for (int i = 0; i < 4; i++) look(2'(i), 2'(3 - i));

        // Byte lanes
        write(2'd1, 16'hABCD, 1, 0);
        write(2'd1, 16'h1234, 0, 1);
        look(2'd1, 2'd1);
        write(2'd1, 16'h5A5A, 1, 1);
        look(2'd1, 2'd0);
        write(2'd1, 16'hFFFF, 0, 0);
        look(2'd0, 2'd1);

        // Window wrap
        idle(); wp_add = 1; wp_in = 6'd62; cycle();
        write(2'd3, 16'h00EE, 1, 1);
        look(2'd3, 2'd2);
        idle(); wp_reset = 1; cycle();
        look(2'd0, 2'd1);

        // WP priority with a same-cycle write at the old window
        idle(); wp_add = 1; wp_in = 6'd4; cycle();
        idle(); wp_add = 1; wp_in = 6'd8; wp_reset = 1;
        laddr = 0; din = 16'h7777; rfl_write = 1; rfh_write = 1; cycle();
        idle(); wp_add = 1; wp_in = 6'd4; cycle();
        look(2'd0, 2'd1);
        idle(); wp_reset = 1; cycle();

        // Flags
        idle(); sr_load = 1; cout_in = 1; zout_in = 1; cycle();
        idle(); c_set = 1; c_reset = 1; z_set = 1; cycle();
        idle(); sr_load = 1; c_set = 1; cout_in = 0; zout_in = 0; cycle();
        idle(); z_set = 1; z_reset = 1; c_reset = 1; cycle();
        look(2'd0, 2'd0);

        // Read-modify-write
        write(2'd0, 16'h0003, 1, 1);
        write(2'd1, 16'h0004, 1, 1);
        idle(); laddr = 0; raddr = 1; din = m_read(2'd0) + m_read(2'd1);
        rfl_write = 1; rfh_write = 1; cycle();
        look(2'd0, 2'd1);

        // Randomised traffic, including occasional mid-stream reset
        for (int n = 0; n < 300; n++) begin
            idle();
            rst_n     = ($urandom_range(0, 39) != 0);
            wp_in     = 6'($urandom);
            wp_add    = ($urandom_range(0, 5) == 0);
            wp_reset  = ($urandom_range(0, 15) == 0);
            laddr     = 2'($urandom);
            raddr     = 2'($urandom);
            din       = 16'($urandom);
            rfl_write = ($urandom_range(0, 1) == 0);
            rfh_write = ($urandom_range(0, 1) == 0);
            cout_in   = 1'($urandom);
            zout_in   = 1'($urandom);
            sr_load   = ($urandom_range(0, 2) == 0);
            c_set     = ($urandom_range(0, 5) == 0);
            c_reset   = ($urandom_range(0, 5) == 0);
            z_set     = ($urandom_range(0, 5) == 0);
            z_reset   = ($urandom_range(0, 5) == 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) look(2'(i), 2'(i ^ 1));

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_window_register_file
